uart_rx_framed: RTL
===================

UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 217, meaning clk cycles per bit; legal range 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY_MODE, default 0, meaning 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked; legal 1 or 2.
REQ-005 SHALL have port clk  input  1  the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port rx_in  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port out_data  output  DATA_BITS  received word, LSB first on the line.
REQ-009 SHALL have port out_valid  output  1  out_data, parity_err and frame_err are valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the word when high with out_valid.
REQ-011 SHALL have port parity_err  output  1  parity mismatch on the held word; 0 when PARITY_MODE=0.
REQ-012 SHALL have port frame_err  output  1  a stop bit of the held word sampled low.
REQ-013 SHALL have port overrun_err  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-014 SHALL pass rx_in through a 2-flop synchroniser; all sampling uses the synchronised signal.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL leave IDLE for START on a synchronised low; the bit counter clears.
REQ-017 SHALL sample in START at count (CLOCKS_PER_BIT-1)/2, go to DATA if low, else back to IDLE without any output.
REQ-018 SHALL sample DATA, PARITY and STOP bits at count CLOCKS_PER_BIT-1 of each bit period, with the counter restarting at 0.
REQ-019 SHALL shift DATA_BITS samples LSB first, then go to PARITY if PARITY_MODE!=0, else to STOP.
REQ-020 SHALL set parity_err when the XOR of data and parity bit is 1 (even) or 0 (odd).
REQ-021 SHALL check STOP_BITS stop samples and set frame_err if any is low.
REQ-022 SHALL return to IDLE in the cycle after the last stop sample, so a following start edge is accepted with no gap.
REQ-023 SHALL load out_data, parity_err and frame_err and assert out_valid one cycle after the last stop sample, including erroneous frames.
REQ-024 SHALL hold out_valid and the held word stable until a cycle with out_ready=1, then clear out_valid on the next edge.
REQ-025 SHALL load the new word when a frame completes in the same cycle as acceptance (out_valid=1, out_ready=1); out_valid stays 1 and no overrun is flagged.
REQ-026 SHALL keep the old word, discard the new frame, and pulse overrun_err for one cycle when a frame completes while out_valid=1 and out_ready=0.
REQ-027 SHALL size the bit counter to $clog2(CLOCKS_PER_BIT) bits and the index counter to $clog2(DATA_BITS+1) bits; no wrap occurs within a bit.

Reset
REQ-028 SHALL on rst_n low immediately force state IDLE, counters 0, synchroniser flops 1, out_data 0, out_valid 0, parity_err 0, frame_err 0, overrun_err 0.
REQ-029 SHALL on reset mid-frame drop the partial frame; after release, reception starts only on a new falling edge.

Configuration
REQ-030 SHALL, with UART_RX_MAJORITY_EN defined, take each sample (START and all later bits) as the 2-of-3 majority of the synchronised line at the nominal sample count and the two preceding cycles.
REQ-031 SHALL, without UART_RX_MAJORITY_EN, take each sample as the single synchronised value at the nominal sample count; frame timing is identical in both builds.

Structure
REQ-032 SHALL place the state typedef, the parity-mode constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2) and legal-range constants in package uart_pkg.
REQ-033 SHALL implement synchroniser plus optional majority voter as sub-module uart_rx_sampler; the FSM, shifter and output register stay in uart_rx_framed.

Verification (CLOCKS_PER_BIT=16 unless stated)
REQ-034 SHALL cover the 8N1 byte 0xA5 with out_ready=1 -> out_valid is one cycle high 1 cycle after the stop mid-sample, out_data=0xA5, and both error flags are 0.
REQ-035 SHALL cover DATA_BITS=7, PARITY_MODE=2 with 0x35 and a wrong parity bit -> out_data=0x35 and parity_err=1; with correct parity, parity_err=0.
REQ-036 SHALL cover STOP_BITS=2 with the second stop bit driven low -> frame_err=1, then a back-to-back frame 0x3C is received correctly.
REQ-037 SHALL cover a low glitch of 3 cycles on an idle line -> START aborts to IDLE and out_valid stays 0.
REQ-038 SHALL cover out_ready=0 while 0x11 then 0x22 arrive -> out_data stays 0x11 and overrun_err pulses once at the completion of 0x22.
REQ-039 SHALL cover a 1-cycle low spike at the mid-bit of a data 1 with UART_RX_MAJORITY_EN defined -> the bit reads 1; without the macro -> the bit reads 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int CPB_MIN       = 8;
  localparam int CPB_MAX       = 65535;
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the serial line plus the bit-sample value.
// Defining UART_RX_MAJORITY_EN makes rx_sample a 2-of-3 vote over the last three synchronised cycles.
module uart_rx_sampler (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic rx_sync,
  output logic rx_sample
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = rx_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rx_sync = sync_q;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is the previous synchronised cycle, hist_q[1] the one before it
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = {hist_q[0], sync_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rx_sample = (sync_q & hist_q[0]) | (sync_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign rx_sample = sync_q;
`endif

endmodule

// File: rtl/uart_rx_framed.sv
// Framed UART receiver: start/data/parity/stop FSM, shifter and a one-word output holding register.
// Sample filtering is selected by UART_RX_MAJORITY_EN inside uart_rx_sampler.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 217,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MID       = CW'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST      = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);

  logic rx_sync, rx_sample;

  uart_rx_sampler u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_in     (rx_in),
    .rx_sync   (rx_sync),
    .rx_sample (rx_sample)
  );

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 ovr_q, ovr_d;
  logic                 frame_done;
  logic                 bit_tick;
  logic                 par_x;
  logic                 perr_new;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;
    bit_tick   = (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        ferr_d = 1'b0;
        if (!rx_sync) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          state_d = rx_sample ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {rx_sample, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          cnt_d     = '0;
          par_bit_d = rx_sample;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~rx_sample;
          idx_d  = idx_q + 1'b1;
          if (idx_q == IDX_STOP_LAST) begin
            idx_d      = '0;
            state_d    = IDLE;
            frame_done = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    par_x = (^shift_q) ^ par_bit_q;
    if (PARITY_MODE == PAR_EVEN)     perr_new = par_x;
    else if (PARITY_MODE == PAR_ODD) perr_new = ~par_x;
    else                             perr_new = 1'b0;

    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    perr_d      = perr_q;
    ferr_out_d  = ferr_out_q;
    ovr_d       = 1'b0;

    // A frame completing during an accept cycle replaces the word instead of overrunning
    if (frame_done) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = shift_q;
        perr_d      = perr_new;
        ferr_out_d  = ferr_d;
        out_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      ferr_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      perr_q      <= 1'b0;
      ferr_out_q  <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      ferr_q      <= ferr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      perr_q      <= perr_d;
      ferr_out_q  <= ferr_out_d;
      ovr_q       <= ovr_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_out_q;
  assign overrun_err = ovr_q;

endmodule
